dual_writer_reg: RTL and testbench

Single-driver register shared by two writers, with round-robin arbitration and a req/ack handshake. This is the legal way to let two independent sources update one variable: one always block owns the register, and the writers request access instead of assigning it directly. It sits between any two producers, such as an AND-path and an OR-path computation, and the shared result register.

---
 rtl/dual_writer_reg.sv | 110 +++++++++++
 tb/tb_dual_writer_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_writer_reg.sv
// dual_writer_reg: one register, two writers. The register has a single owner
// (this block); writers ask for access with req/ack and a round-robin pointer
// settles ties so neither writer can starve the other.
module dual_writer_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic [7:0]       conflicts
);

  // IDLE samples requests; ACK0/ACK1 each last exactly one cycle and carry
  // the acknowledge pulse for the writer just served.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK0 = 2'd1,
    ACK1 = 2'd2
  } state_e;

  localparam logic [7:0] CONFLICTS_MAX = 8'hFF;

  state_e           state_q,     state_d;
  logic             prio_q,      prio_d;       // writer that wins the next tie
  logic [WIDTH-1:0] q_q,         q_d;
  logic [7:0]       conflicts_q, conflicts_d;

  // Grant decision taken in IDLE; only meaningful when grant_valid is set.
  logic             grant_valid;
  logic             grant_id;
  logic             tie;

  // Arbitration: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    tie         = req0 && req1;
    grant_valid = req0 || req1;
    if (tie) begin
      grant_id = prio_q;
    end else begin
      grant_id = req1;
    end
  end

  // Next-state, next-register and counter logic.
  always_comb begin
    // NOTE: every signal assigned here gets a hold/default value first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    prio_d      = prio_q;
    q_d         = q_q;
    conflicts_d = conflicts_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          // The loser of this grant (or the idle writer) gets the next tie.
          prio_d  = ~grant_id;
          q_d     = grant_id ? data1 : data0;
          state_d = grant_id ? ACK1 : ACK0;
          if (tie && (conflicts_q != CONFLICTS_MAX)) begin
            conflicts_d = conflicts_q + 8'd1;
          end
        end
      end
      // Requests are ignored while acknowledging; the writer drops req in
      // this cycle, or keeps it to ask for another write.
      ACK0, ACK1: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, shared register and conflict counter.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: reset is asynchronous, so an ack in flight drops at once and the
    // register returns to RESET_VAL without waiting for a clock edge.
    if (!reset_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      q_q         <= RESET_VAL;
      conflicts_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the values
      // that existed before this edge, independent of statement order.
      state_q     <= state_d;
      prio_q      <= prio_d;
      q_q         <= q_d;
      conflicts_q <= conflicts_d;
    end
  end

  // Moore outputs decoded from state and the owned registers.
  assign ack0      = (state_q == ACK0);
  assign ack1      = (state_q == ACK1);
  assign busy      = (state_q != IDLE);
  assign q         = q_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_dual_writer_reg.sv
// Directed bench for dual_writer_reg: reset, single writes, ties, round-robin
// alternation, a writer holding req through ack, and counter saturation.
module tb_dual_writer_reg;

  logic       clk;
  logic       reset_n;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic [7:0] q;
  logic       busy;
  logic [7:0] conflicts;

  int n_cmp  = 0;
  int n_fail = 0;

  dual_writer_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .ack1      (ack1),
    .q         (q),
    .busy      (busy),
    .conflicts (conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs are read there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          g;
  int unsigned exp_cnt;

  initial begin
    reset_n = 1'b0;
    req0    = 1'b0;
    data0   = 8'h00;
    req1    = 1'b0;
    data1   = 8'h00;

    // Reset values hold before any clock edge.
    #1;
    check("rst_q", q, 8'h00);
    check("rst_ack0", ack0, 1'b0);
    check("rst_ack1", ack1, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_conflicts", conflicts, 8'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("idle_q", q, 8'h00);
    check("idle_busy", busy, 1'b0);

    // Single write from writer 0.
    req0  = 1'b1;
    data0 = 8'h3C;
    step();
    check("w0_q", q, 8'h3C);
    check("w0_ack0", ack0, 1'b1);
    check("w0_ack1", ack1, 1'b0);
    check("w0_busy", busy, 1'b1);
    req0 = 1'b0;
    step();
    check("w0_ack0_drop", ack0, 1'b0);
    check("w0_ack1_low", ack1, 1'b0);
    check("w0_busy_drop", busy, 1'b0);
    check("w0_q_hold", q, 8'h3C);

    // Asynchronous reset mid-cycle while in ACK0.
    req0  = 1'b1;
    data0 = 8'h77;
    step();
    check("pre_arst_q", q, 8'h77);
    check("pre_arst_ack0", ack0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ack0", ack0, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_q", q, 8'h00);
    req0 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Tie right after reset: prio=0, writer 0 first, writer 1 two cycles later.
    req0  = 1'b1;
    data0 = 8'hAA;
    req1  = 1'b1;
    data1 = 8'h55;
    step();
    check("tie_q0", q, 8'hAA);
    check("tie_ack0", ack0, 1'b1);
    check("tie_ack1_low", ack1, 1'b0);
    check("tie_conflicts", conflicts, 8'd1);
    req0 = 1'b0;
    step();
    check("tie_gap_busy", busy, 1'b0);
    check("tie_gap_q", q, 8'hAA);
    step();
    check("tie_q1", q, 8'h55);
    check("tie_ack1", ack1, 1'b1);
    check("tie_ack0_low", ack0, 1'b0);
    check("tie_conflicts_hold", conflicts, 8'd1);
    req1 = 1'b0;
    step();
    check("tie_end_busy", busy, 1'b0);

    // Both writers keep coming back: grants alternate 0,1,0,1,0 (prio=0).
    req0  = 1'b1;
    data0 = 8'hC3;
    req1  = 1'b1;
    data1 = 8'h5A;
    g = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("alt_ack0", ack0, (g == 0));
      check("alt_ack1", ack1, (g == 1));
      check("alt_q", q, (g == 1) ? 8'h5A : 8'hC3);
      if (g == 0) req0 = 1'b0; else req1 = 1'b0;
      step();
      check("alt_idle", busy, 1'b0);
      if (g == 0) req0 = 1'b1; else req1 = 1'b1;
      g = 1 - g;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("alt_conflicts", conflicts, 8'd6);

    // Writer 0 keeps req0 high through its ack: rewritten every 2 cycles.
    req0  = 1'b1;
    data0 = 8'h11;
    step();
    check("hold_q", q, 8'h11);
    check("hold_ack0_a", ack0, 1'b1);
    step();
    check("hold_gap", ack0, 1'b0);
    step();
    check("hold_ack0_b", ack0, 1'b1);
    check("hold_q_b", q, 8'h11);
    // Writer 1 joins; prio points to it after writer 0's grant.
    req1  = 1'b1;
    data1 = 8'h22;
    step();
    check("join_gap", busy, 1'b0);
    step();
    check("join_ack1", ack1, 1'b1);
    check("join_ack0_low", ack0, 1'b0);
    check("join_q", q, 8'h22);
    check("join_conflicts", conflicts, 8'd7);
    req1 = 1'b0;
    step();
    step();
    check("back0_ack0", ack0, 1'b1);
    check("back0_q", q, 8'h11);
    req0 = 1'b0;
    step();

    // 300 consecutive ties: counter climbs from 7 and sticks at 255.
    // prio is 1 here, so odd-numbered grants go to writer 1.
    req0  = 1'b1;
    data0 = 8'h81;
    req1  = 1'b1;
    data1 = 8'h18;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1 || i == 247 || i == 248 || i == 249 || i == 300) begin
        exp_cnt = (7 + i > 255) ? 255 : 7 + i;
        check("sat_conflicts", conflicts, exp_cnt);
        check("sat_ack1", ack1, (i % 2 == 1));
        check("sat_q", q, (i % 2 == 1) ? 8'h18 : 8'h81);
      end
      step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check("sat_final", conflicts, 8'd255);
    check("sat_final_busy", busy, 1'b0);

    // Reset clears the saturated counter and the register.
    reset_n = 1'b0;
    #1;
    check("rst2_conflicts", conflicts, 8'd0);
    check("rst2_q", q, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
